// File: rtl/tile_line_fetcher_if.sv
// rtl/tile_line_fetcher_if.sv - tile-map RAM read bus between the line fetcher and the map RAM
interface tile_line_fetcher_if #(
  parameter int MAP_AW = 9,
  parameter int ID_W   = 4
);
  logic [MAP_AW-1:0] map_addr;
  logic [ID_W-1:0]   map_rdata;

  modport master (output map_addr, input map_rdata);
  modport slave  (input map_addr, output map_rdata);
endinterface

// File: rtl/tile_line_fetcher.sv
// rtl/tile_line_fetcher.sv - per-scanline tile-map prefetch into a shadow buffer, swapped at end of line
// Front buffer drives the registered pixel path; shadow is filled during horizontal blank.
module tile_line_fetcher #(
  parameter int MAP_COLS = 20,
  parameter int MAP_ROWS = 15,
  parameter int ID_W     = 4,
  parameter int MAP_AW   = 9
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [9:0]            DrawX,
  input  logic [9:0]            DrawY,
  tile_line_fetcher_if.master   map_bus,
  output logic [ID_W-1:0]       tile_id,
  output logic [4:0]            tile_col,
  output logic [4:0]            tile_row,
  output logic                  tile_valid,
  output logic                  fetch_busy,
  output logic                  fetch_late
);

  localparam int COL_W = $clog2(MAP_COLS);
  localparam int VIS_W = MAP_COLS * 32;
  localparam int VIS_H = MAP_ROWS * 32;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [MAP_AW-1:0]   base_q, base_d;
  logic                ready_q, ready_d;
  logic                loaded_q, loaded_d;
  logic                late_q, late_d;
  logic [ID_W-1:0]     front_q [MAP_COLS];
  logic [ID_W-1:0]     front_d [MAP_COLS];
  logic [ID_W-1:0]     shadow_q [MAP_COLS];
  logic [ID_W-1:0]     shadow_d [MAP_COLS];
  logic [ID_W-1:0]     tile_id_q, tile_id_d;
  logic [4:0]          tile_col_q, tile_col_d;
  logic [4:0]          tile_row_q, tile_row_d;
  logic                tile_valid_q, tile_valid_d;

  logic [9:0]          next_y;
  logic                fetch_req;
  logic                trigger;
  logic                swap_pt;
  logic                x_vis;
  logic [4:0]          pix_idx;

  assign next_y    = (DrawY == 10'd524) ? 10'd0 : DrawY + 10'd1;
  assign fetch_req = next_y < 10'(VIS_H);
  assign trigger   = (DrawX == 10'(VIS_W)) && fetch_req && (state_q == IDLE);
  assign swap_pt   = DrawX == 10'd799;
  assign x_vis     = DrawX < 10'(VIS_W);
  assign pix_idx   = DrawX[9:5];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trigger) state_d = FETCH;
      FETCH:   if (col_q == COL_W'(MAP_COLS - 1)) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    map_bus.map_addr = '0;
    fetch_busy       = 1'b0;
    case (state_q)
      FETCH: begin
        map_bus.map_addr = base_q + MAP_AW'(col_q);
        fetch_busy       = 1'b1;
      end
      DRAIN:   fetch_busy = 1'b1;
      default: ;
    endcase
  end

  // RAM data lags the address by one cycle, so each FETCH cycle stores the previous column.
  always_comb begin
    col_d    = col_q;
    base_d   = base_q;
    ready_d  = ready_q;
    loaded_d = loaded_q;
    late_d   = late_q;
    front_d  = front_q;
    shadow_d = shadow_q;
    if (trigger) begin
      col_d  = '0;
      base_d = MAP_AW'(next_y[9:5]) * MAP_AW'(MAP_COLS);
    end
    if (state_q == FETCH) begin
      col_d = col_q + COL_W'(1);
      if (col_q != '0) shadow_d[col_q - COL_W'(1)] = map_bus.map_rdata;
    end
    if (swap_pt) begin
      if (ready_q) begin
        front_d  = shadow_q;
        ready_d  = 1'b0;
        loaded_d = 1'b1;
      end else if (fetch_req) begin
        late_d = 1'b1;
      end
    end
    if (state_q == DRAIN) begin
      shadow_d[MAP_COLS-1] = map_bus.map_rdata;
      ready_d              = 1'b1;
      col_d                = '0;
    end
  end

  always_comb begin
    tile_id_d    = x_vis ? front_q[pix_idx] : '0;
    tile_col_d   = DrawX[4:0];
    tile_row_d   = DrawY[4:0];
    tile_valid_d = loaded_q && x_vis && (DrawY < 10'(VIS_H));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      col_q        <= '0;
      base_q       <= '0;
      ready_q      <= 1'b0;
      loaded_q     <= 1'b0;
      late_q       <= 1'b0;
      front_q      <= '{default: '0};
      shadow_q     <= '{default: '0};
      tile_id_q    <= '0;
      tile_col_q   <= '0;
      tile_row_q   <= '0;
      tile_valid_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      base_q       <= base_d;
      ready_q      <= ready_d;
      loaded_q     <= loaded_d;
      late_q       <= late_d;
      front_q      <= front_d;
      shadow_q     <= shadow_d;
      tile_id_q    <= tile_id_d;
      tile_col_q   <= tile_col_d;
      tile_row_q   <= tile_row_d;
      tile_valid_q <= tile_valid_d;
    end
  end

  assign tile_id    = tile_id_q;
  assign tile_col   = tile_col_q;
  assign tile_row   = tile_row_q;
  assign tile_valid = tile_valid_q;
  assign fetch_late = late_q;

endmodule

// File: doc/tile_line_fetcher.md
# tile_line_fetcher

Per-scanline tile-map prefetcher sitting between the VGA timing counters and the color mapper. During each horizontal blank it reads the next visible line's row of tile IDs from the synchronous tile-map RAM into a shadow line buffer, swaps it in at end of line, and for every visible pixel emits the tile ID plus in-tile column/row. The color mapper uses these to address sprite ROM instead of hard-coding wall/floor regions.

## Interface
- MAP_COLS, 20, tiles per map row (640/32)
- MAP_ROWS, 15, tile rows per screen (480/32)
- ID_W, 4, tile ID width
- MAP_AW, 9, tile-map RAM address width (must hold MAP_COLS*MAP_ROWS-1 = 299)

- Clk  in  1  pixel clock, one DrawX step per cycle
- Reset  in  1  synchronous, active-high
- DrawX  in  10  current pixel column, 0..799 (visible 0..639)
- DrawY  in  10  current line, 0..524 (visible 0..479)
- map_addr  out  MAP_AW  tile-map RAM read address
- map_rdata  in  ID_W  tile-map RAM data, valid exactly 1 cycle after map_addr
- tile_id  out  ID_W  tile ID of pixel (DrawX,DrawY) from previous cycle
- tile_col  out  5  DrawX[4:0] of previous cycle
- tile_row  out  5  DrawY[4:0] of previous cycle
- tile_valid  out  1  previous-cycle pixel is visible and front buffer loaded
- fetch_busy  out  1  high while FSM in FETCH or DRAIN
- fetch_late  out  1  sticky: swap point reached with fetch incomplete

## Operation
- Two line buffers, front and shadow, MAP_COLS entries of ID_W each; front feeds outputs, shadow is written by the fetch FSM.
- Next line: ny = (DrawY==524) ? 0 : DrawY+1. Fetch required iff ny < 480; target row tr = ny[9:5].
- Trigger: DrawX==640 and fetch required and FSM in IDLE. Trigger while not IDLE is ignored.
- FSM states:
  - IDLE: map_addr held at 0. On trigger -> FETCH with col=0, base = tr*MAP_COLS (MAP_AW-bit arithmetic, no overflow for tr<=14).
  - FETCH: map_addr = base+col; each cycle col++; shadow[col-1] <= map_rdata for col>=1. After issuing col=MAP_COLS-1 -> DRAIN.
  - DRAIN: shadow[MAP_COLS-1] <= map_rdata; set ready flag -> IDLE.
- Swap: at DrawX==799, if ready: front <= shadow, ready <= 0, loaded <= 1. If fetch was required for this line but ready==0 (FSM still busy), set fetch_late, do not swap; front keeps old contents.
- No fetch for lines whose ny >= 480; front retains last row, outputs masked by tile_valid.
- Pixel path (registered, 1 cycle): tile_id <= front[DrawX[9:5]] when DrawX<640, else 0; tile_col <= DrawX[4:0]; tile_row <= DrawY[4:0]; tile_valid <= loaded && DrawX<640 && DrawY<480.
- Re-fetch every visible line even if tile row unchanged (simplifies control; 20 reads fit in 160-cycle blank).
- Reset (any time, including mid-FETCH): FSM -> IDLE, col=0, ready=0, loaded=0, fetch_late=0, both buffers cleared to 0; any in-flight read discarded.

## Timing
- Reset values: map_addr=0, tile_id=0, tile_col=0, tile_row=0, tile_valid=0, fetch_busy=0, fetch_late=0.
- Trigger seen in cycle T (DrawX==640): map_addr=base+0 in T+1, base+19 in T+20; DRAIN in T+21; ready and fetch_busy=0 from T+22.
- Swap at DrawX==799 (~T+159): new front visible on tile_id for pixel DrawX=0 of next line, one cycle after DrawX=0 presented.
- Pixel output latency exactly 1 cycle; tile_id/tile_col/tile_row/tile_valid change together.
- First visible frame after reset: line 0 displays with tile_valid=1 only if line 524 fetch completed; lines before first swap show tile_valid=0.
- fetch_late clears only on Reset.

## Test plan
- Reset mid-FETCH (Reset at T+10): next cycle all outputs 0, fetch_busy=0, tile_valid=0; no map_addr activity until next DrawX==640.
- Map RAM model tile(r,c)=(r+c)&15, full frame scan: at DrawY=100,DrawX=200 (row 3, col 6) -> next cycle tile_id=9, tile_col=8, tile_row=4, tile_valid=1.
- Fetch sequence on DrawY=31, DrawX=640: map_addr 20..39 on consecutive cycles T+1..T+20, fetch_busy high T+1..T+21.
- Wrap: DrawY=524, DrawX=640 triggers row 0 fetch (map_addr 0..19); DrawY=479..523 produce no map_addr activity; tile_valid=0 for DrawY>=480 and DrawX>=640.
- Stall model: force DrawX to jump 640->799 after 5 cycles -> fetch_late=1, front unchanged, fetch_late stays 1 until Reset.
- Ignored retrigger: DrawX held at 640 for 3 cycles -> exactly one 20-address sequence issued.
